// File: rtl/mod_n_counter_scheduler_if.sv
// Bundles the requester-side and increment-unit-side signals of
// mod_n_counter_scheduler.
//   req/clr       : per-requester increment request and synchronous clear
//   grant/wrap    : one-cycle write-back pulse and zero-result flag
//   count         : flattened counts, requester i at [i*WIDTH +: WIDTH]
//   busy          : scheduler is mid-operation
//   inc_data_in   : operand to the external mod-N increment unit
//   inc_data_out  : registered result from the increment unit
//   inc_rst       : synchronous reset for the increment unit
// master = environment side, slave = scheduler side.
interface mod_n_counter_scheduler_if #(
   parameter int WIDTH = 32,
   parameter int NREQ  = 4
);
   logic [NREQ-1:0]       req;
   logic [NREQ-1:0]       clr;
   logic [NREQ-1:0]       grant;
   logic [NREQ-1:0]       wrap;
   logic [NREQ*WIDTH-1:0] count;
   logic                  busy;
   logic [WIDTH-1:0]      inc_data_in;
   logic [WIDTH-1:0]      inc_data_out;
   logic                  inc_rst;

   modport master (
      output req, clr, inc_data_out,
      input  grant, wrap, count, busy, inc_data_in, inc_rst
   );

   modport slave (
      input  req, clr, inc_data_out,
      output grant, wrap, count, busy, inc_data_in, inc_rst
   );
endinterface

// File: rtl/mod_n_counter_scheduler.sv
// Round-robin scheduler that time-shares one external mod-N increment unit
// among NREQ per-requester counters. Each update takes three cycles:
// IDLE (arbitrate, load operand), ISSUE (operand stable at the unit),
// WAIT (result arrives, written back on the exit edge).
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : mod_n_counter_scheduler_if.slave (req, clr, grant, wrap, count,
//          busy, inc_data_in, inc_data_out, inc_rst)
module mod_n_counter_scheduler #(
   parameter int N     = 256,
   parameter int WIDTH = 32,
   parameter int NREQ  = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   mod_n_counter_scheduler_if.slave    bus
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   if (NREQ < 2) begin : g_bad_nreq
      $error("NREQ must be at least 2");
   end
   if (N < 2 || $clog2(N) > WIDTH) begin : g_bad_n
      $error("N must be at least 2 and N-1 must fit in WIDTH bits");
   end

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t            state, state_nx;
   logic [PW-1:0]     ptr, sel, winner;
   logic              found;
   logic              load, wb;
   logic [WIDTH-1:0]  cnt [NREQ];
   logic [WIDTH-1:0]  inc_data_in_q;
   logic [NREQ-1:0]   grant_q, wrap_q;
   logic              inc_rst_q;

   // Round-robin search starting at ptr, wrapping modulo NREQ.
   always_comb begin
      int unsigned idx;
      idx    = 0;
      winner = '0;
      found  = 1'b0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = k + 32'(ptr);
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && bus.req[idx]) begin
            found  = 1'b1;
            winner = PW'(idx);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      wb       = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               load     = 1'b1;
               state_nx = ISSUE;
            end
         end
         ISSUE: state_nx = WAIT;
         WAIT: begin
            wb       = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr           <= '0;
         sel           <= '0;
         inc_data_in_q <= '0;
         grant_q       <= '0;
         wrap_q        <= '0;
         inc_rst_q     <= 1'b1;
         for (int unsigned i = 0; i < NREQ; i++) cnt[i] <= '0;
      end else begin
         inc_rst_q <= 1'b0;
         grant_q   <= '0;
         wrap_q    <= '0;
         if (load) begin
            sel           <= winner;
            inc_data_in_q <= cnt[winner];
         end
         if (wb) begin
            grant_q[sel] <= 1'b1;
            // A coincident clear overrides the result, so no wrap is reported.
            wrap_q[sel]  <= (bus.inc_data_out == '0) && !bus.clr[sel];
            ptr          <= (32'(sel) == NREQ - 1) ? '0 : sel + 1'b1;
         end
         for (int unsigned i = 0; i < NREQ; i++) begin
            if (bus.clr[i])                   cnt[i] <= '0;
            else if (wb && sel == PW'(i))     cnt[i] <= bus.inc_data_out;
         end
      end
   end

   always_comb begin
      bus.count = '0;
      for (int unsigned i = 0; i < NREQ; i++) bus.count[i*WIDTH +: WIDTH] = cnt[i];
   end

   assign bus.grant       = grant_q;
   assign bus.wrap        = wrap_q;
   assign bus.inc_data_in = inc_data_in_q;
   assign bus.inc_rst     = inc_rst_q;
   assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_mod_n_counter_scheduler.sv
// Testbench for mod_n_counter_scheduler (N=5, WIDTH=8, NREQ=4) with a
// transaction-level reference model and a behavioural increment unit.
module tb_mod_n_counter_scheduler;

   localparam int N     = 5;
   localparam int WIDTH = 8;
   localparam int NREQ  = 4;

   logic clk;
   logic rst;

   mod_n_counter_scheduler_if #(.WIDTH(WIDTH), .NREQ(NREQ)) dut_if ();

   mod_n_counter_scheduler #(.N(N), .WIDTH(WIDTH), .NREQ(NREQ)) dut (
      .clk (clk),
      .rst (rst),
      .bus (dut_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External mod-N increment unit: one registered cycle of latency.
   always @(posedge clk) begin
      if (dut_if.inc_rst) dut_if.inc_data_out <= '0;
      else                dut_if.inc_data_out <= WIDTH'((int'(dut_if.inc_data_in) + 1) % N);
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   // Reference model: one pending update at a time, written back two cycles
   // after its selection cycle, visible as a grant the cycle after that.
   int         m_cnt [NREQ];
   int         m_ptr;
   bit         m_pend;
   int         m_sel, m_op, m_due;
   logic [3:0] m_grant, m_wrap;
   bit         m_inc_rst;
   int         cyc = 0;

   task automatic model_reset();
      for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
      m_ptr     = 0;
      m_pend    = 0;
      m_sel     = 0;
      m_op      = 0;
      m_due     = 0;
      m_grant   = '0;
      m_wrap    = '0;
      m_inc_rst = 1;
   endtask

   task automatic model_step(input logic [3:0] r, input logic [3:0] c);
      int nc [NREQ];
      logic [3:0] ng, nw;
      bit hit;
      ng = '0;
      nw = '0;
      nc = m_cnt;
      for (int i = 0; i < NREQ; i++) if (c[i]) nc[i] = 0;
      if (m_pend && cyc == m_due) begin
         ng[m_sel] = 1'b1;
         if (!c[m_sel]) begin
            nc[m_sel] = (m_op + 1) % N;
            nw[m_sel] = (nc[m_sel] == 0);
         end
         m_ptr  = (m_sel + 1) % NREQ;
         m_pend = 0;
      end else if (!m_pend && r != 0) begin
         hit = 0;
         for (int k = 0; k < NREQ; k++) begin
            if (!hit && r[(m_ptr + k) % NREQ]) begin
               hit   = 1;
               m_sel = (m_ptr + k) % NREQ;
            end
         end
         m_op   = m_cnt[m_sel];
         m_due  = cyc + 2;
         m_pend = 1;
      end
      m_cnt     = nc;
      m_grant   = ng;
      m_wrap    = nw;
      m_inc_rst = 0;
      cyc++;
   endtask

   // Entered and left at a falling edge: drive inputs, compare outputs,
   // advance the model, then cross one rising edge.
   task automatic do_cycle(input logic [3:0] r, input logic [3:0] c);
      dut_if.req = r;
      dut_if.clr = c;
      check($sformatf("grant@%0d", cyc), 32'(dut_if.grant), 32'(m_grant));
      check($sformatf("wrap@%0d", cyc), 32'(dut_if.wrap), 32'(m_wrap));
      check($sformatf("busy@%0d", cyc), 32'(dut_if.busy), 32'(m_pend));
      check($sformatf("inc_rst@%0d", cyc), 32'(dut_if.inc_rst), 32'(m_inc_rst));
      for (int i = 0; i < NREQ; i++)
         check($sformatf("count%0d@%0d", i, cyc), 32'(dut_if.count[i*WIDTH +: WIDTH]), 32'(m_cnt[i]));
      model_step(r, c);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst        = 1'b0;
      dut_if.req = '0;
      dut_if.clr = '0;
      #1;
      for (int i = 0; i < NREQ; i++)
         check($sformatf("rst_count%0d", i), 32'(dut_if.count[i*WIDTH +: WIDTH]), 32'd0);
      check("rst_grant", 32'(dut_if.grant), 32'd0);
      check("rst_wrap", 32'(dut_if.wrap), 32'd0);
      check("rst_busy", 32'(dut_if.busy), 32'd0);
      check("rst_inc_rst", 32'(dut_if.inc_rst), 32'd1);
      check("rst_inc_data_in", 32'(dut_if.inc_data_in), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
   endtask

   initial begin
      logic [3:0] r, c;
      rst        = 1'b1;
      dut_if.req = '0;
      dut_if.clr = '0;
      @(negedge clk);
      do_reset();

      // Single requester held: 1,2,3,4,0 with wrap on the fifth grant.
      repeat (16) do_cycle(4'b0001, 4'b0000);
      // All requesters held: rotating grants.
      repeat (20) do_cycle(4'b1111, 4'b0000);
      repeat (3)  do_cycle(4'b0000, 4'b0000);
      // Serve requester 1 so the search starts at 2, then wrap to 0.
      repeat (3)  do_cycle(4'b0010, 4'b0000);
      repeat (6)  do_cycle(4'b0011, 4'b0000);
      repeat (3)  do_cycle(4'b0000, 4'b0000);
      // Clear of requester 2 during its WAIT cycle.
      do_cycle(4'b0100, 4'b0000);
      do_cycle(4'b0100, 4'b0000);
      do_cycle(4'b0000, 4'b0100);
      repeat (3) do_cycle(4'b0000, 4'b0000);
      // Request pulse while busy is never served.
      do_cycle(4'b0001, 4'b0000);
      do_cycle(4'b0010, 4'b0000);
      repeat (5) do_cycle(4'b0000, 4'b0000);
      // Bring count2 to 3, start another update, reset during WAIT.
      repeat (9) do_cycle(4'b0100, 4'b0000);
      do_cycle(4'b0100, 4'b0000);
      do_cycle(4'b0000, 4'b0000);
      check("pre_rst_busy", 32'(dut_if.busy), 32'd1);
      do_reset();
      repeat (8) do_cycle(4'b1111, 4'b0000);

      // Randomized traffic with occasional clears and resets.
      repeat (500) begin
         r = 4'($urandom_range(0, 15));
         c = ($urandom_range(0, 7) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
         if ($urandom_range(0, 149) == 0) do_reset();
         else do_cycle(r, c);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
